// File: rtl/test_result_monitor.sv
// Passive monitor on the core write port: watches for the result byte,
// reports pass/fail/timeout and keeps write/cycle statistics.
//
// Ports:
//   ph1          clock, rising edge
//   reset        synchronous, active-high
//   address      core address bus (16)
//   write_data   core store data (8)
//   memwrite     core write strobe
//   done         terminal state reached
//   pass/fail    result byte matched / mismatched EXPECT
//   timeout      no result byte within TIMEOUT_CYCLES run cycles
//   write_count  writes observed, saturating
//   cycle_count  run cycles elapsed, saturating
//   last_addr    address of the most recent write
//   last_data    data of the most recent write
module test_result_monitor #(
  parameter logic [15:0] CHECK_ADDR     = 16'h0040,
  parameter logic [7:0]  EXPECT         = 8'h42,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd60
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  write_data,
  input  logic        memwrite,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [7:0]  write_count,
  output logic [15:0] cycle_count,
  output logic [15:0] last_addr,
  output logic [7:0]  last_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TMO
  } state_t;

  state_t state;
  state_t state_nx;

  logic check_wr;
  logic tmo_hit;
  logic pass_d;
  logic fail_d;
  logic tmo_d;

  assign check_wr = memwrite && (address == CHECK_ADDR);

  // A zero budget disables the timeout entirely.
  assign tmo_hit = (TIMEOUT_CYCLES != 16'd0) &&
                   (cycle_count == TIMEOUT_CYCLES - 16'd1);

  always_ff @(posedge ph1) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Check write outranks the timeout when both land in one cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: state_nx = S_RUN;
      S_RUN: begin
        if (check_wr)
          state_nx = (write_data == EXPECT) ? S_PASS : S_FAIL;
        else if (tmo_hit)
          state_nx = S_TMO;
      end
      S_PASS,
      S_FAIL,
      S_TMO:  state_nx = state;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    pass_d = (state_nx == S_PASS);
    fail_d = (state_nx == S_FAIL);
    tmo_d  = (state_nx == S_TMO);
  end

  // Flags are registered copies of the next-state decode, so they
  // appear on the same edge that enters the terminal state.
  always_ff @(posedge ph1) begin
    if (reset) begin
      done    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      done    <= pass_d | fail_d | tmo_d;
      pass    <= pass_d;
      fail    <= fail_d;
      timeout <= tmo_d;
    end
  end

  // cycle_count only advances on edges that stay in RUN, so it holds
  // the count of completed run cycles once a terminal state is entered.
  always_ff @(posedge ph1) begin
    if (reset) begin
      write_count <= 8'd0;
      cycle_count <= 16'd0;
      last_addr   <= 16'd0;
      last_data   <= 8'd0;
    end else if (state == S_RUN) begin
      if (memwrite) begin
        if (write_count != 8'hFF)
          write_count <= write_count + 8'd1;
        last_addr <= address;
        last_data <= write_data;
      end
      if (state_nx == S_RUN && cycle_count != 16'hFFFF)
        cycle_count <= cycle_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_test_result_monitor.sv
// Directed self-checking bench for test_result_monitor.
// Table of single-cycle vectors plus multi-cycle timeout/saturation runs.
module tb_test_result_monitor;

  logic        ph1 = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  write_data;
  logic        memwrite;

  logic        done_a, pass_a, fail_a, tmo_a;
  logic [7:0]  wc_a, ld_a;
  logic [15:0] cc_a, la_a;

  logic        done_b, pass_b, fail_b, tmo_b;
  logic [7:0]  wc_b, ld_b;
  logic [15:0] cc_b, la_b;

  int ncmp = 0;
  int nfail = 0;

  always #5 ph1 = ~ph1;

  test_result_monitor dut_a (
    .ph1(ph1), .reset(reset), .address(address),
    .write_data(write_data), .memwrite(memwrite),
    .done(done_a), .pass(pass_a), .fail(fail_a),
    .timeout(tmo_a), .write_count(wc_a),
    .cycle_count(cc_a), .last_addr(la_a), .last_data(ld_a)
  );

  test_result_monitor #(.TIMEOUT_CYCLES(16'd0)) dut_b (
    .ph1(ph1), .reset(reset), .address(address),
    .write_data(write_data), .memwrite(memwrite),
    .done(done_b), .pass(pass_b), .fail(fail_b),
    .timeout(tmo_b), .write_count(wc_b),
    .cycle_count(cc_b), .last_addr(la_b), .last_data(ld_b)
  );

  typedef struct {
    logic        rst;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        we;
    logic        done;
    logic        pass;
    logic        fail;
    logic        tmo;
    logic [7:0]  wc;
    logic [15:0] cc;
    logic [15:0] la;
    logic [7:0]  ld;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [15:0] a,
                     input logic [7:0] d, input logic we,
                     input logic dn, input logic p, input logic f,
                     input logic t, input logic [7:0] wc,
                     input logic [15:0] cc, input logic [15:0] la,
                     input logic [7:0] ld);
    vec_t v;
    v.rst = rst; v.addr = a; v.data = d; v.we = we;
    v.done = dn; v.pass = p; v.fail = f; v.tmo = t;
    v.wc = wc; v.cc = cc; v.la = la; v.ld = ld;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [15:0] a,
                       input logic [7:0] d, input logic we);
    reset = rst; address = a; write_data = d; memwrite = we;
    @(posedge ph1);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic dn,
                       input logic p, input logic f, input logic t,
                       input logic [7:0] wc, input logic [15:0] cc,
                       input logic [15:0] la, input logic [7:0] ld);
    chk({tag, ".done"}, 32'(done_a), 32'(dn));
    chk({tag, ".pass"}, 32'(pass_a), 32'(p));
    chk({tag, ".fail"}, 32'(fail_a), 32'(f));
    chk({tag, ".timeout"}, 32'(tmo_a), 32'(t));
    chk({tag, ".write_count"}, 32'(wc_a), 32'(wc));
    chk({tag, ".cycle_count"}, 32'(cc_a), 32'(cc));
    chk({tag, ".last_addr"}, 32'(la_a), 32'(la));
    chk({tag, ".last_data"}, 32'(ld_a), 32'(ld));
  endtask

  initial begin
    reset = 1'b1; address = '0; write_data = '0; memwrite = 1'b0;

    // rst  addr      data   we   done pass fail tmo wc     cc      la        ld
    add(1, 16'h0000, 8'h00, 0,   0, 0, 0, 0, 8'd0, 16'd0, 16'h0000, 8'h00);
    add(0, 16'h0000, 8'h00, 0,   0, 0, 0, 0, 8'd0, 16'd0, 16'h0000, 8'h00);
    add(0, 16'h0010, 8'h10, 1,   0, 0, 0, 0, 8'd1, 16'd1, 16'h0010, 8'h10);
    add(1, 16'h0040, 8'h42, 1,   0, 0, 0, 0, 8'd0, 16'd0, 16'h0000, 8'h00);
    add(0, 16'h0000, 8'h00, 0,   0, 0, 0, 0, 8'd0, 16'd0, 16'h0000, 8'h00);
    add(0, 16'h0010, 8'h10, 1,   0, 0, 0, 0, 8'd1, 16'd1, 16'h0010, 8'h10);
    add(0, 16'h0040, 8'h42, 1,   1, 1, 0, 0, 8'd2, 16'd1, 16'h0040, 8'h42);
    add(0, 16'h0040, 8'h41, 1,   1, 1, 0, 0, 8'd2, 16'd1, 16'h0040, 8'h42);
    add(0, 16'h0000, 8'h00, 0,   1, 1, 0, 0, 8'd2, 16'd1, 16'h0040, 8'h42);
    add(1, 16'h0000, 8'h00, 0,   0, 0, 0, 0, 8'd0, 16'd0, 16'h0000, 8'h00);
    add(0, 16'h0000, 8'h00, 0,   0, 0, 0, 0, 8'd0, 16'd0, 16'h0000, 8'h00);
    add(0, 16'h0000, 8'h00, 0,   0, 0, 0, 0, 8'd0, 16'd1, 16'h0000, 8'h00);
    add(0, 16'h0040, 8'h42, 1,   1, 1, 0, 0, 8'd1, 16'd1, 16'h0040, 8'h42);
    add(1, 16'h0000, 8'h00, 0,   0, 0, 0, 0, 8'd0, 16'd0, 16'h0000, 8'h00);
    add(0, 16'h0000, 8'h00, 0,   0, 0, 0, 0, 8'd0, 16'd0, 16'h0000, 8'h00);
    add(0, 16'h0040, 8'h41, 1,   1, 0, 1, 0, 8'd1, 16'd0, 16'h0040, 8'h41);
    add(0, 16'h0040, 8'h42, 1,   1, 0, 1, 0, 8'd1, 16'd0, 16'h0040, 8'h41);
    add(0, 16'h0010, 8'h99, 1,   1, 0, 1, 0, 8'd1, 16'd0, 16'h0040, 8'h41);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].addr, vecs[i].data, vecs[i].we);
      chk_a($sformatf("vec%0d", i), vecs[i].done, vecs[i].pass,
            vecs[i].fail, vecs[i].tmo, vecs[i].wc, vecs[i].cc,
            vecs[i].la, vecs[i].ld);
    end

    // Timeout: 60 idle run cycles, counter stops at 59 and freezes.
    drive(1, 16'h0, 8'h0, 0);
    drive(0, 16'h0, 8'h0, 0);
    for (int i = 0; i < 59; i++) drive(0, 16'h0, 8'h0, 0);
    chk_a("tmo_pre", 0, 0, 0, 0, 8'd0, 16'd59, 16'h0, 8'h0);
    drive(0, 16'h0, 8'h0, 0);
    chk_a("tmo_hit", 1, 0, 0, 1, 8'd0, 16'd59, 16'h0, 8'h0);
    for (int i = 0; i < 5; i++) drive(0, 16'h0040, 8'h42, 1);
    chk_a("tmo_frozen", 1, 0, 0, 1, 8'd0, 16'd59, 16'h0, 8'h0);

    // Check write landing in cycle 59 beats the timeout.
    drive(1, 16'h0, 8'h0, 0);
    drive(0, 16'h0, 8'h0, 0);
    for (int i = 0; i < 59; i++) drive(0, 16'h0, 8'h0, 0);
    drive(0, 16'h0040, 8'h42, 1);
    chk_a("tie_pass", 1, 1, 0, 0, 8'd1, 16'd59, 16'h0040, 8'h42);
    drive(0, 16'h0, 8'h0, 0);
    chk_a("tie_hold", 1, 1, 0, 0, 8'd1, 16'd59, 16'h0040, 8'h42);

    // Saturation on the timeout-disabled instance.
    drive(1, 16'h0, 8'h0, 0);
    drive(0, 16'h0, 8'h0, 0);
    for (int i = 0; i < 300; i++)
      drive(0, 16'h0010, 8'(i), 1);
    chk("sat.write_count", 32'(wc_b), 32'hFF);
    chk("sat.done", 32'(done_b), 32'd0);
    chk("sat.timeout", 32'(tmo_b), 32'd0);
    chk("sat.cycle_count", 32'(cc_b), 32'd300);
    chk("sat.last_data", 32'(ld_b), 32'h2B);
    drive(0, 16'h0040, 8'h42, 1);
    chk("sat.pass", 32'(pass_b), 32'd1);
    chk("sat.done_after", 32'(done_b), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
